// File: rtl/frame_scan_controller.sv
// Frame read sequencer: start-up vertical sync, per-line blanking, and a
// bottom-up (BMP order) row/column scan emitting one even/odd pixel pair
// address per beat under a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; all outputs low
// VSYNC | start-up delay, vertical_Pulse high
// HSYNC | per-line blanking, all pulses low
// DATA  | line active, one pixel pair offered per beat
// DONE  | one-cycle end-of-frame pulse
module frame_scan_controller #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int START_DELAY  = 100,
  parameter int HSYNC_DELAY  = 160,
  parameter int CNT_WIDTH    = 10,
  parameter int DLY_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pix_ready,
  output logic                  vertical_Pulse,
  output logic                  horizontal_Pulse,
  output logic                  pix_valid,
  output logic [CNT_WIDTH-1:0]  row,
  output logic [CNT_WIDTH-1:0]  col,
  output logic [ADDR_WIDTH-1:0] addr_even,
  output logic [ADDR_WIDTH-1:0] addr_odd,
  output logic                  busy,
  output logic                  done_Flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_HSYNC,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [DLY_WIDTH-1:0] SD_LAST  = DLY_WIDTH'(START_DELAY - 1);
  localparam logic [DLY_WIDTH-1:0] HD_LAST  = DLY_WIDTH'(HSYNC_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMAGE_WIDTH - 2);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMAGE_HEIGHT - 1);

  state_t                state, state_nx;
  logic [DLY_WIDTH-1:0]  dly, dly_nx;
  logic [CNT_WIDTH-1:0]  row_q, row_nx;
  logic [CNT_WIDTH-1:0]  col_q, col_nx;
  logic [ADDR_WIDTH-1:0] ae_q, ae_nx;
  logic [ADDR_WIDTH-1:0] ao_q, ao_nx;

  // Display row 0 is the last line stored in the BMP image, hence the flip.
  function automatic logic [ADDR_WIDTH-1:0] pair_addr(input logic [CNT_WIDTH-1:0] r,
                                                      input logic [CNT_WIDTH-1:0] c);
    logic [ADDR_WIDTH-1:0] line;
    line = ADDR_WIDTH'(IMAGE_HEIGHT - 1) - ADDR_WIDTH'(r);
    return ADDR_WIDTH'(3) * (line * ADDR_WIDTH'(IMAGE_WIDTH) + ADDR_WIDTH'(c));
  endfunction

  // State, counters and addresses; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      dly   <= '0;
      row_q <= '0;
      col_q <= '0;
      ae_q  <= '0;
      ao_q  <= '0;
    end else begin
      state <= state_nx;
      dly   <= dly_nx;
      row_q <= row_nx;
      col_q <= col_nx;
      ae_q  <= ae_nx;
      ao_q  <= ao_nx;
    end
  end

  // Next-state, counter updates and the address for the next registered row/col.
  always_comb begin
    state_nx = state;
    dly_nx   = dly;
    row_nx   = row_q;
    col_nx   = col_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_VSYNC;
          dly_nx   = '0;
          row_nx   = '0;
          col_nx   = '0;
        end
      end
      S_VSYNC: begin
        if (dly == SD_LAST) begin
          state_nx = S_HSYNC;
          dly_nx   = '0;
        end else begin
          dly_nx = dly + 1'b1;
        end
      end
      S_HSYNC: begin
        if (dly == HD_LAST) begin
          state_nx = S_DATA;
          dly_nx   = '0;
        end else begin
          dly_nx = dly + 1'b1;
        end
      end
      S_DATA: begin
        if (pix_ready) begin
          if (col_q == COL_LAST) begin
            col_nx = '0;
            if (row_q == ROW_LAST) begin
              state_nx = S_DONE;
            end else begin
              row_nx   = row_q + 1'b1;
              state_nx = S_HSYNC;
            end
          end else begin
            col_nx = col_q + CNT_WIDTH'(2);
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        row_nx   = '0;
        col_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        dly_nx   = '0;
        row_nx   = '0;
        col_nx   = '0;
      end
    endcase
    // Addresses read as zero while idle so an idle block presents all-zero outputs.
    if (state_nx == S_IDLE) begin
      ae_nx = '0;
      ao_nx = '0;
    end else begin
      ae_nx = pair_addr(row_nx, col_nx);
      ao_nx = ae_nx + ADDR_WIDTH'(3);
    end
  end

  assign vertical_Pulse   = (state == S_VSYNC);
  assign horizontal_Pulse = (state == S_DATA);
  assign pix_valid        = (state == S_DATA);
  assign busy             = (state != S_IDLE);
  assign done_Flag        = (state == S_DONE);
  assign row              = row_q;
  assign col              = col_q;
  assign addr_even        = ae_q;
  assign addr_odd         = ao_q;

endmodule
